// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. Bytes written on the parallel
//               port are queued in a circular FIFO and serialised on txd as
//               start + 8 data bits (LSB first) + optional parity + stop.
//               The bit period comes from an internal down-counter running
//               on the system clock.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous active-high reset
//               wr_en    - write strobe, accepted when FIFO is not full
//               wr_data  - byte to transmit
//               full     - FIFO holds 2^DEPTH_LOG2 entries
//               empty    - FIFO holds no entries
//               count    - FIFO occupancy (frame in flight not counted)
//               overflow - sticky: a write was attempted while full
//               busy     - a frame is on the line
//               txd      - serial output, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKDIV     = 5208,
    parameter bit PARITYEN   = 1'b1,
    parameter bit PARITYMODE = 1'b1,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  txd
);

    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(c_depth);
    localparam logic [15:0]         c_bit_reload = 16'(CLKDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [7:0]              r_mem [c_depth];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_overflow;

    logic [7:0]              r_shift;
    logic [2:0]              r_bit_idx;
    logic                    r_parity;
    logic [15:0]             r_bit_cnt;
    logic                    r_txd;
    logic                    r_busy;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_bit_end;
    logic                    w_txd_bit;

    assign w_full    = (r_count == c_full_count);
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle never makes room for a write while full.
    assign w_push    = wr_en && !w_full;
    assign w_bit_end = (r_state != S_IDLE) && (r_bit_cnt == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, pop request and line level for the current bit
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd_bit   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd_bit = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd_bit = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = PARITYEN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_txd_bit = r_parity;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed on the data array)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser datapath and registered line outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_txd  <= w_txd_bit;
            r_busy <= (r_state != S_IDLE);
            if (w_pop) begin
                // Parity is latched from the popped byte so later FIFO
                // traffic cannot disturb the frame in flight.
                r_shift   <= r_mem[r_rd_ptr];
                r_parity  <= (^r_mem[r_rd_ptr]) ^ PARITYMODE;
                r_bit_idx <= '0;
                r_bit_cnt <= c_bit_reload;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_bit_cnt <= c_bit_reload;
                    if (r_state == S_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign txd      = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Three instances share
//               the write port: odd parity, even parity, and no parity.
//               A frame-schedule model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLKDIV = 4;
    localparam int DL2    = 2;
    localparam int DEPTH  = 4;
    localparam int ND     = 3;
    localparam int NMAX   = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [7:0]     wr_data;
    logic           full_o  [ND];
    logic           empty_o [ND];
    logic           ovf_o   [ND];
    logic           busy_o  [ND];
    logic           txd_o   [ND];
    logic [DL2:0]   cnt_o   [ND];

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // Model: per instance, list of accepted bytes with accept edge and pop edge.
    int         acc_e [ND][NMAX];
    int         pop_e [ND][NMAX];
    logic [7:0] dat   [ND][NMAX];
    int         nacc  [ND];
    bit         ovf   [ND];
    int         busy_cnt [ND];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKDIV(CLKDIV), .PARITYEN(1'b1), .PARITYMODE(1'b1), .DEPTH_LOG2(DL2)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o[0]), .empty(empty_o[0]), .count(cnt_o[0]),
        .overflow(ovf_o[0]), .busy(busy_o[0]), .txd(txd_o[0]));

    uart_tx_fifo #(.CLKDIV(CLKDIV), .PARITYEN(1'b1), .PARITYMODE(1'b0), .DEPTH_LOG2(DL2)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o[1]), .empty(empty_o[1]), .count(cnt_o[1]),
        .overflow(ovf_o[1]), .busy(busy_o[1]), .txd(txd_o[1]));

    uart_tx_fifo #(.CLKDIV(CLKDIV), .PARITYEN(1'b0), .PARITYMODE(1'b1), .DEPTH_LOG2(DL2)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o[2]), .empty(empty_o[2]), .count(cnt_o[2]),
        .overflow(ovf_o[2]), .busy(busy_o[2]), .txd(txd_o[2]));

    function automatic int pen(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    function automatic int pm(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic int flen(input int d);
        return (10 + pen(d)) * CLKDIV;
    endfunction

    // FIFO occupancy right after edge ee.
    function automatic int m_count(input int d, input int ee);
        int c;
        c = 0;
        for (int k = 0; k < nacc[d]; k++) begin
            if (acc_e[d][k] <= ee) c++;
            if (pop_e[d][k] <= ee) c--;
        end
        return c;
    endfunction

    // {busy, txd} right after edge ee. A frame popped at edge p occupies
    // the line for edges p+1 .. p+frame_length.
    function automatic logic [1:0] m_line(input int d, input int ee);
        int st;
        int j;
        int ones;
        logic b;
        for (int k = 0; k < nacc[d]; k++) begin
            st = pop_e[d][k] + 1;
            if (ee >= st && ee < st + flen(d)) begin
                j = (ee - st) / CLKDIV;
                if (j == 0) begin
                    b = 1'b0;
                end else if (j <= 8) begin
                    b = dat[d][k][j-1];
                end else if (pen(d) == 1 && j == 9) begin
                    ones = $countones(dat[d][k]);
                    b = ((ones + pm(d)) % 2) == 1;
                end else begin
                    b = 1'b1;
                end
                return {1'b1, b};
            end
        end
        return 2'b01;
    endfunction

    // Apply the inputs seen at edge ne to the model.
    task automatic model_edge(input int d, input int ne, input logic we,
                              input logic [7:0] wd, input logic r);
        int k;
        int p;
        if (r) begin
            nacc[d] = 0;
            ovf[d]  = 1'b0;
        end else if (we) begin
            if (m_count(d, ne - 1) < DEPTH && nacc[d] < NMAX) begin
                k = nacc[d];
                acc_e[d][k] = ne;
                dat[d][k]   = wd;
                p = ne + 1;
                if (k > 0 && pop_e[d][k-1] + flen(d) > p) p = pop_e[d][k-1] + flen(d);
                pop_e[d][k] = p;
                nacc[d]++;
            end else begin
                ovf[d] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] ln;
        int c;
        for (int d = 0; d < ND; d++) begin
            ln = m_line(d, e);
            c  = m_count(d, e);
            chk($sformatf("txd%0d@%0d", d, e),   32'(txd_o[d]),   32'(ln[0]));
            chk($sformatf("busy%0d@%0d", d, e),  32'(busy_o[d]),  32'(ln[1]));
            chk($sformatf("count%0d@%0d", d, e), 32'(cnt_o[d]),   32'(c));
            chk($sformatf("empty%0d@%0d", d, e), 32'(empty_o[d]), 32'(c == 0));
            chk($sformatf("full%0d@%0d", d, e),  32'(full_o[d]),  32'(c == DEPTH));
            chk($sformatf("ovf%0d@%0d", d, e),   32'(ovf_o[d]),   32'(ovf[d]));
        end
    endtask

    // Drive inputs for the next edge, advance one cycle, check on the falling edge.
    task automatic tick(input logic we, input logic [7:0] d, input logic r);
        wr_en   = we;
        wr_data = d;
        rst     = r;
        for (int k = 0; k < ND; k++) model_edge(k, e + 1, we, d, r);
        @(posedge clk);
        e++;
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        check_all();
        for (int k = 0; k < ND; k++) busy_cnt[k] += int'(busy_o[k]);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        for (int k = 0; k < ND; k++) begin
            nacc[k]     = 0;
            ovf[k]      = 1'b0;
            busy_cnt[k] = 0;
        end
        @(negedge clk);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);

        // Single frame of 0xA3 on all three parity configurations.
        for (int k = 0; k < ND; k++) busy_cnt[k] = 0;
        tick(1'b1, 8'hA3, 1'b0);
        repeat (60) tick(1'b0, 8'h00, 1'b0);
        chk("busy_len_odd",  32'(busy_cnt[0]), 32'd44);
        chk("busy_len_even", 32'(busy_cnt[1]), 32'd44);
        chk("busy_len_nopar", 32'(busy_cnt[2]), 32'd40);

        // 0x07 exercises the other parity polarity.
        tick(1'b1, 8'h07, 1'b0);
        repeat (50) tick(1'b0, 8'h00, 1'b0);

        // Burst of 6 into a 4-deep FIFO: the sixth is rejected.
        for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0);
        chk("ovf_burst", 32'(ovf_o[0]), 32'd1);
        repeat (5 * 44 + 20) tick(1'b0, 8'h00, 1'b0);
        chk("ovf_sticky", 32'(ovf_o[0]), 32'd1);

        // Full FIFO, write coinciding with the STOP-end pop.
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0);
        while (e + 1 < pop_e[0][1]) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'($urandom), 1'b0);
        chk("count_fullpop", 32'(cnt_o[0]), 32'd3);
        chk("ovf_fullpop",   32'(ovf_o[0]), 32'd1);
        repeat (4 * 44 + 20) tick(1'b0, 8'h00, 1'b0);

        // Write with count = 2 on the STOP-end pop: count holds at 2.
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0);
        while (e + 1 < pop_e[0][1]) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'($urandom), 1'b0);
        chk("count_hold2", 32'(cnt_o[0]), 32'd2);
        repeat (4 * 44 + 20) tick(1'b0, 8'h00, 1'b0);

        // Reset in the middle of the DATA bits of 0x55 with two queued.
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'($urandom), 1'b0);
        tick(1'b1, 8'($urandom), 1'b0);
        repeat (8) tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        chk("rst_mid_txd",   32'(txd_o[0]),   32'd1);
        chk("rst_mid_busy",  32'(busy_o[0]),  32'd0);
        chk("rst_mid_count", 32'(cnt_o[0]),   32'd0);
        chk("rst_mid_empty", 32'(empty_o[0]), 32'd1);
        repeat (50) tick(1'b0, 8'h00, 1'b0);

        // Randomised traffic: sparse, then dense enough to overflow.
        repeat (1500) tick($urandom_range(0, 24) == 0, 8'($urandom), 1'b0);
        repeat (400)  tick($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
        repeat (300)  tick(1'b0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
